id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the RISC-V core, sitting directly upstream of the ALU unit. Each cycle it captures decoded operands and control, derives the 4-bit ALU control code, and presents forwarded operands A/B and the control code to the ALU. It also detects load-use hazards, inserting bubbles and handling stall and flush.

---
 rtl/id_ex_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It captures decoded operands and control, derives the
// 4-bit ALU control code, detects load-use hazards and forwards operands from
// EX/MEM and MEM/WB to the ALU.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RADDR-1:0] id_rs1,
  input  logic [RADDR-1:0] id_rs2,
  input  logic [RADDR-1:0] id_rd,
  input  logic [1:0]       id_alu_op,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic             exmem_reg_write,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic             memwb_reg_write,
  input  logic [XLEN-1:0]  memwb_result,
  output logic             load_use_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_control,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Everything that travels from ID to EX as one register; a bubble is all zeros.
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic [RADDR-1:0] rd;
    logic             alu_src;
    logic [3:0]       alu_control;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             illegal;
  } stage_t;

  stage_t     stage_reg;
  stage_t     stage_next;
  stage_t     id_stage;
  logic [3:0] dec_control;
  logic       dec_illegal;

  // Decode the ALU control code; unknown arithmetic functions fall back to ADD and flag illegal.
  always_comb begin
    dec_control = ALU_ADD;
    dec_illegal = 1'b0;
    case (id_alu_op)
      2'b00: dec_control = ALU_ADD;
      2'b01: dec_control = ALU_SUB;
      2'b10: begin
        case (id_funct3)
          3'b111:  dec_control = ALU_AND;
          3'b110:  dec_control = ALU_OR;
          // SUB only exists in register-register form; ADDI ignores funct7.
          3'b000:  dec_control = (!id_alu_src && id_funct7_5) ? ALU_SUB : ALU_ADD;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // The instruction waiting in EX is a load whose destination the decode slot reads.
  assign load_use_stall = id_valid && stage_reg.valid && stage_reg.mem_read &&
                          (stage_reg.rd != '0) &&
                          ((stage_reg.rd == id_rs1) || (stage_reg.rd == id_rs2));

  // Pack the decode-side fields into the stage record.
  always_comb begin
    id_stage             = '0;
    id_stage.valid       = 1'b1;
    id_stage.pc          = id_pc;
    id_stage.rs1_data    = id_rs1_data;
    id_stage.rs2_data    = id_rs2_data;
    id_stage.imm         = id_imm;
    id_stage.rs1         = id_rs1;
    id_stage.rs2         = id_rs2;
    id_stage.rd          = id_rd;
    id_stage.alu_src     = id_alu_src;
    id_stage.alu_control = dec_control;
    id_stage.reg_write   = id_reg_write;
    id_stage.mem_read    = id_mem_read;
    id_stage.mem_write   = id_mem_write;
    id_stage.branch      = id_branch;
    id_stage.illegal     = dec_illegal;
  end

  // Next-state priority: flush bubble, then stall hold, then hazard/empty-slot bubble, then load.
  always_comb begin
    stage_next = stage_reg;
    if (flush) begin
      stage_next = '0;
    end else if (stall) begin
      stage_next = stage_reg;
    end else if (load_use_stall || !id_valid) begin
      stage_next = '0;
    end else begin
      stage_next = id_stage;
    end
  end

  // Stage register with immediate clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  // Operand forwarding, one identical path per source operand (0 = rs1, 1 = rs2).
  logic [1:0][RADDR-1:0] fwd_rs;
  logic [1:0][XLEN-1:0]  fwd_rf;
  logic [1:0][XLEN-1:0]  fwd_data;

  assign fwd_rs[0] = stage_reg.rs1;
  assign fwd_rs[1] = stage_reg.rs2;
  assign fwd_rf[0] = stage_reg.rs1_data;
  assign fwd_rf[1] = stage_reg.rs2_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_exmem;
      logic hit_memwb;
      // x0 is never forwarded; the younger EX/MEM result wins over MEM/WB.
      assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == fwd_rs[gi]);
      assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == fwd_rs[gi]);
      assign fwd_data[gi] = hit_exmem ? exmem_result :
                            hit_memwb ? memwb_result : fwd_rf[gi];
    end
  endgenerate

  assign alu_a         = fwd_data[0];
  assign alu_b         = stage_reg.alu_src ? stage_reg.imm : fwd_data[1];
  assign ex_store_data = fwd_data[1];
  assign alu_control   = stage_reg.alu_control;
  assign ex_valid      = stage_reg.valid;
  assign ex_pc         = stage_reg.pc;
  assign ex_imm        = stage_reg.imm;
  assign ex_rd         = stage_reg.rd;
  assign ex_reg_write  = stage_reg.reg_write;
  assign ex_mem_read   = stage_reg.mem_read;
  assign ex_mem_write  = stage_reg.mem_write;
  assign ex_branch     = stage_reg.branch;
  assign ex_illegal    = stage_reg.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the ID/EX register and forwarding rules.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;

  logic clk = 1'b0;
  logic reset, stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RADDR-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_alu_op;
  logic [2:0] id_funct3;
  logic id_funct7_5, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [RADDR-1:0] exmem_rd, memwb_rd;
  logic exmem_reg_write, memwb_reg_write;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic load_use_stall, ex_valid;
  logic [XLEN-1:0] alu_a, alu_b, ex_store_data, ex_pc, ex_imm;
  logic [3:0] alu_control;
  logic [RADDR-1:0] ex_rd;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;

  int compared   = 0;
  int mismatched = 0;

  id_ex_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result), .load_use_stall(load_use_stall), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Behavioural model of what sits in EX.
  typedef struct {
    logic v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0] rs1, rs2, rd;
    logic src;
    logic [3:0] ctl;
    logic rw, mr, mw, br, ill;
  } ex_t;

  ex_t m;

  function automatic ex_t bubble();
    ex_t b;
    b.v = 0; b.pc = 0; b.d1 = 0; b.d2 = 0; b.imm = 0;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.src = 0; b.ctl = 0;
    b.rw = 0; b.mr = 0; b.mw = 0; b.br = 0; b.ill = 0;
    return b;
  endfunction

  function automatic logic [3:0] ref_ctl(logic [1:0] op, logic [2:0] f3, logic f7, logic src);
    if (op == 2'b01) return C_SUB;
    if (op == 2'b10) begin
      if (f3 == 3'd7) return C_AND;
      if (f3 == 3'd6) return C_OR;
      if (f3 == 3'd0 && !src && f7) return C_SUB;
    end
    return C_ADD;
  endfunction

  function automatic logic ref_ill(logic [1:0] op, logic [2:0] f3);
    return (op == 2'b11) || (op == 2'b10 && f3 != 3'd0 && f3 != 3'd6 && f3 != 3'd7);
  endfunction

  function automatic ex_t load_model();
    ex_t n;
    n.v = 1; n.pc = id_pc; n.d1 = id_rs1_data; n.d2 = id_rs2_data; n.imm = id_imm;
    n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd; n.src = id_alu_src;
    n.ctl = ref_ctl(id_alu_op, id_funct3, id_funct7_5, id_alu_src);
    n.ill = ref_ill(id_alu_op, id_funct3);
    n.rw = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write; n.br = id_branch;
    return n;
  endfunction

  function automatic logic [31:0] ref_fwd(logic [4:0] rs, logic [31:0] rf);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == rs) return memwb_result;
    return rf;
  endfunction

  function automatic logic ref_lus();
    return id_valid && m.v && m.mr && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  // Advance one clock: model the edge from the inputs present before it.
  task automatic tick();
    ex_t n;
    if (reset) n = bubble();
    else if (flush) n = bubble();
    else if (stall) n = m;
    else if (ref_lus() || !id_valid) n = bubble();
    else n = load_model();
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic set_id(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic src, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic mr);
    id_valid = 1; id_alu_op = op; id_funct3 = f3; id_funct7_5 = f7; id_alu_src = src;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_reg_write = 1; id_mem_read = mr; id_mem_write = 0;
    id_branch = (op == 2'b01);
  endtask

  task automatic clear_fwd();
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    set_id(2'b10, 3'd0, 0, 0, 5'd1, 5'd2, 5'd3, 32'd9, 32'd4, 32'd0, 0);
    id_pc = 32'h100;
    tick();
    reset = 1;
    m = bubble();
    #1;
    compared++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal,
         load_use_stall, alu_control} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b required 0",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal,
                load_use_stall, alu_control});
    end
    compared++;
    if ((alu_a | alu_b | ex_store_data | ex_pc | ex_imm | 32'(ex_rd)) !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_data: a=%h b=%h sd=%h pc=%h imm=%h rd=%0d required all 0",
               alu_a, alu_b, ex_store_data, ex_pc, ex_imm, ex_rd);
    end
    tick();
    reset = 0;
    set_id(2'b10, 3'd0, 0, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0);
    tick();
    compared++;
    if ({alu_a, alu_b, alu_control, ex_valid} !== {32'd5, 32'd7, C_ADD, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_first_add: a=%0d b=%0d ctl=%b v=%b required 5 7 0010 1",
               alu_a, alu_b, alu_control, ex_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_decode();
    // op, funct3, funct7_5, alu_src, expected control, expected illegal
    logic [1:0] ops [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [2:0] f3s [8] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd1, 3'd5, 3'd2, 3'd0};
    logic       f7s [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       srcs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] ctls[8] = '{C_SUB, C_ADD, C_AND, C_OR, C_ADD, C_ADD, C_SUB, C_ADD};
    logic       ills[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      set_id(ops[i], f3s[i], f7s[i], srcs[i], 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'h7F0 + i, 0);
      tick();
      compared++;
      if ({alu_control, ex_illegal, ex_valid} !== {ctls[i], ills[i], 1'b1}) begin
        mismatched++;
        $display("FAIL decode[%0d]: ctl=%b ill=%b v=%b required %b %b 1",
                 i, alu_control, ex_illegal, ex_valid, ctls[i], ills[i]);
      end
      compared++;
      if (alu_b !== (srcs[i] ? 32'h7F0 + i : 32'd22)) begin
        mismatched++;
        $display("FAIL decode_b[%0d]: got %h required %h", i, alu_b,
                 srcs[i] ? 32'h7F0 + i : 32'd22);
      end
    end
    $display("test_decode done");
  endtask

  task automatic test_forwarding();
    clear_fwd();
    set_id(2'b10, 3'd0, 0, 1, 5'd4, 5'd4, 5'd9, 32'h11, 32'h22, 32'h44, 0);
    tick();
    id_valid = 0;
    exmem_rd = 4; exmem_reg_write = 1; exmem_result = 32'hAA;
    memwb_rd = 4; memwb_reg_write = 1; memwb_result = 32'hBB;
    #1;
    compared++;
    if ({alu_a, ex_store_data, alu_b} !== {32'hAA, 32'hAA, 32'h44}) begin
      mismatched++;
      $display("FAIL fwd_exmem: a=%h sd=%h b=%h required aa aa 44", alu_a, ex_store_data, alu_b);
    end
    exmem_reg_write = 0;
    #1;
    compared++;
    if ({alu_a, ex_store_data} !== {32'hBB, 32'hBB}) begin
      mismatched++;
      $display("FAIL fwd_memwb: a=%h sd=%h required bb bb", alu_a, ex_store_data);
    end
    memwb_rd = 5;
    #1;
    compared++;
    if ({alu_a, ex_store_data} !== {32'h11, 32'h22}) begin
      mismatched++;
      $display("FAIL fwd_none: a=%h sd=%h required 11 22", alu_a, ex_store_data);
    end
    set_id(2'b10, 3'd0, 0, 0, 5'd0, 5'd0, 5'd9, 32'h33, 32'h66, 32'h0, 0);
    tick();
    exmem_rd = 0; exmem_reg_write = 1; memwb_rd = 0; memwb_reg_write = 1;
    #1;
    compared++;
    if ({alu_a, alu_b} !== {32'h33, 32'h66}) begin
      mismatched++;
      $display("FAIL fwd_x0: a=%h b=%h required 33 66", alu_a, alu_b);
    end
    clear_fwd();
    $display("test_forwarding done");
  endtask

  task automatic test_load_use();
    clear_fwd();
    set_id(2'b00, 3'd2, 0, 1, 5'd2, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd8, 1);
    tick();
    set_id(2'b10, 3'd0, 0, 0, 5'd5, 5'd1, 5'd6, 32'h0, 32'h3, 32'd0, 0);
    #1;
    compared++;
    if (load_use_stall !== 1'b1) begin
      mismatched++;
      $display("FAIL lu_detect: got %b required 1", load_use_stall);
    end
    tick();
    compared++;
    if ({ex_valid, ex_reg_write, load_use_stall} !== 3'b000) begin
      mismatched++;
      $display("FAIL lu_bubble: v=%b rw=%b lus=%b required 0 0 0", ex_valid, ex_reg_write,
               load_use_stall);
    end
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'hDEAD;
    tick();
    compared++;
    if ({ex_valid, alu_a, alu_b, alu_control} !== {1'b1, 32'hDEAD, 32'h3, C_ADD}) begin
      mismatched++;
      $display("FAIL lu_release: v=%b a=%h b=%h ctl=%b required 1 dead 3 0010",
               ex_valid, alu_a, alu_b, alu_control);
    end
    clear_fwd();
    set_id(2'b00, 3'd2, 0, 1, 5'd2, 5'd0, 5'd0, 32'h0, 32'd0, 32'd8, 1);
    tick();
    set_id(2'b10, 3'd0, 0, 0, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'd0, 0);
    #1;
    compared++;
    if (load_use_stall !== 1'b0) begin
      mismatched++;
      $display("FAIL lu_x0: got %b required 0", load_use_stall);
    end
    $display("test_load_use done");
  endtask

  task automatic test_stall_flush();
    clear_fwd();
    set_id(2'b10, 3'd7, 0, 0, 5'd3, 5'd4, 5'd7, 32'h50, 32'h60, 32'd0, 0);
    id_pc = 32'h200;
    tick();
    stall = 1;
    set_id(2'b01, 3'd0, 0, 0, 5'd8, 5'd9, 5'd10, 32'h1, 32'h2, 32'd0, 0);
    id_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({ex_valid, ex_pc, alu_control, ex_rd, alu_a} !== {1'b1, 32'h200, C_AND, 5'd7, 32'h50}) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: v=%b pc=%h ctl=%b rd=%0d a=%h required 1 200 0000 7 50",
                 i, ex_valid, ex_pc, alu_control, ex_rd, alu_a);
      end
    end
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'hC0DE;
    #1;
    compared++;
    if (alu_a !== 32'hC0DE) begin
      mismatched++;
      $display("FAIL stall_fwd_live: got %h required c0de", alu_a);
    end
    flush = 1;
    tick();
    compared++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal} !== 6'd0) begin
      mismatched++;
      $display("FAIL stall_flush: ctrl=%b required 000000",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal});
    end
    flush = 0;
    clear_fwd();
    tick();
    compared++;
    if (ex_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_after_flush: v=%b required 0", ex_valid);
    end
    stall = 0;
    tick();
    stall = 1;
    reset = 1;
    m = bubble();
    #1;
    compared++;
    if ({ex_valid, ex_reg_write} !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_mid_stall: v=%b rw=%b required 0 0", ex_valid, ex_reg_write);
    end
    reset = 0;
    stall = 0;
    id_pc = 32'h400;
    tick();
    compared++;
    if ({ex_valid, ex_pc} !== {1'b1, 32'h400}) begin
      mismatched++;
      $display("FAIL reset_release_load: v=%b pc=%h required 1 400", ex_valid, ex_pc);
    end
    $display("test_stall_flush done");
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, esd;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_alu_op = 2'($urandom); id_funct3 = 3'($urandom); id_funct7_5 = 1'($urandom);
      id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
      id_branch = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom);
      exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom);
      memwb_result = $urandom;
      if (reset) m = bubble();
      #1;
      ea = ref_fwd(m.rs1, m.d1);
      esd = ref_fwd(m.rs2, m.d2);
      eb = m.src ? m.imm : esd;
      compared++;
      if ({alu_a, alu_b, ex_store_data} !== {ea, eb, esd}) begin
        mismatched++;
        $display("FAIL rnd_operands[%0d]: a=%h b=%h sd=%h required %h %h %h",
                 i, alu_a, alu_b, ex_store_data, ea, eb, esd);
      end
      compared++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal, alu_control}
          !== {m.v, m.rw, m.mr, m.mw, m.br, m.ill, m.ctl}) begin
        mismatched++;
        $display("FAIL rnd_ctrl[%0d]: got %b required %b", i,
                 {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal, alu_control},
                 {m.v, m.rw, m.mr, m.mw, m.br, m.ill, m.ctl});
      end
      compared++;
      if ({ex_pc, ex_imm, ex_rd} !== {m.pc, m.imm, m.rd}) begin
        mismatched++;
        $display("FAIL rnd_fields[%0d]: pc=%h imm=%h rd=%0d required %h %h %0d",
                 i, ex_pc, ex_imm, ex_rd, m.pc, m.imm, m.rd);
      end
      compared++;
      if (load_use_stall !== ref_lus()) begin
        mismatched++;
        $display("FAIL rnd_lus[%0d]: got %b required %b", i, load_use_stall, ref_lus());
      end
      tick();
    end
    reset = 0; stall = 0; flush = 0;
    $display("test_random done");
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; id_valid = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_funct3 = 0; id_funct7_5 = 0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
    clear_fwd();
    m = bubble();
    tick();
    reset = 0;
    test_reset();
    test_decode();
    test_forwarding();
    test_load_use();
    test_stall_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
